// File: rtl/vdc_ramctl_if.sv
// Signal bundle between the CPU register file / VRAM and the vdc_ramctl access engine.
// The slave modport is the engine; the master modport is the CPU side plus the RAM itself.
interface vdc_ramctl_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
);
    logic                     slot;
    logic                     upd_ld;
    logic [ADDRESS_WIDTH-1:0] upd_in;
    logic                     src_ld;
    logic [ADDRESS_WIDTH-1:0] src_in;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     start_wr;
    logic                     start_rd;
    logic                     start_blk;
    logic                     blk_copy;
    logic [7:0]               blk_cnt;
    logic                     busy;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_valid;
    logic [ADDRESS_WIDTH-1:0] upd_addr;
    logic [ADDRESS_WIDTH-1:0] src_addr;
    logic                     ram_rd;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dai;
    logic [DATA_WIDTH-1:0]    ram_dao;

    modport slave (
        input  slot, upd_ld, upd_in, src_ld, src_in, wr_data,
               start_wr, start_rd, start_blk, blk_copy, blk_cnt, ram_dao,
        output busy, rd_data, rd_valid, upd_addr, src_addr,
               ram_rd, ram_we, ram_addr, ram_dai
    );

    modport master (
        output slot, upd_ld, upd_in, src_ld, src_in, wr_data,
               start_wr, start_rd, start_blk, blk_copy, blk_cnt, ram_dao,
        input  busy, rd_data, rd_valid, upd_addr, src_addr,
               ram_rd, ram_we, ram_addr, ram_dai
    );
endinterface

// File: rtl/vdc_ramctl.sv
// CPU-side VDC video RAM access engine: single R31 reads/writes plus block fill/copy,
// issuing RAM strobes only in cycles the display fetcher grants (slot).
module vdc_ramctl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic         clk,
    input  logic         reset,
    vdc_ramctl_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_RDCAP = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_CPRD  = 3'd5;
    localparam logic [2:0] S_CPCAP = 3'd6;
    localparam logic [2:0] S_CPWR  = 3'd7;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    logic [2:0]               state,    state_d;
    logic [ADDRESS_WIDTH-1:0] upd_q,    upd_d;
    logic [ADDRESS_WIDTH-1:0] src_q,    src_d;
    logic [8:0]               cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0]    byte_q,   byte_d;
    logic [DATA_WIDTH-1:0]    rd_q,     rd_d;
    logic                     rd_vld_q, rd_vld_d;
    logic                     ram_rd_c, ram_we_c;
    logic                     cnt_last;

    assign cnt_last = (cnt_q == 9'd1);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state;
        upd_d    = upd_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        rd_d     = rd_q;
        rd_vld_d = 1'b0;
        ram_rd_c = 1'b0;
        ram_we_c = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.upd_ld) upd_d = bus.upd_in;
                if (bus.src_ld) src_d = bus.src_in;
                if (bus.start_blk) begin
                    cnt_d   = (bus.blk_cnt == 8'd0) ? 9'd256 : {1'b0, bus.blk_cnt};
                    byte_d  = bus.wr_data;
                    state_d = bus.blk_copy ? S_CPRD : S_FILL;
                end else if (bus.start_wr) begin
                    byte_d  = bus.wr_data;
                    state_d = S_WR;
                end else if (bus.start_rd) begin
                    state_d = S_RD;
                end
            end

            S_WR: begin
                if (bus.slot) begin
                    ram_we_c = 1'b1;
                    upd_d    = upd_q + ADDR_ONE;
                    state_d  = S_IDLE;
                end
            end

            S_RD: begin
                if (bus.slot) begin
                    ram_rd_c = 1'b1;
                    state_d  = S_RDCAP;
                end
            end

            // Capture states complete without a slot: the RAM already produced the data.
            S_RDCAP: begin
                rd_d     = bus.ram_dao;
                rd_vld_d = 1'b1;
                upd_d    = upd_q + ADDR_ONE;
                state_d  = S_IDLE;
            end

            S_FILL: begin
                if (bus.slot) begin
                    ram_we_c = 1'b1;
                    upd_d    = upd_q + ADDR_ONE;
                    cnt_d    = cnt_q - 9'd1;
                    if (cnt_last) state_d = S_IDLE;
                end
            end

            S_CPRD: begin
                if (bus.slot) begin
                    ram_rd_c = 1'b1;
                    src_d    = src_q + ADDR_ONE;
                    state_d  = S_CPCAP;
                end
            end

            S_CPCAP: begin
                rd_d    = bus.ram_dao;
                state_d = S_CPWR;
            end

            S_CPWR: begin
                if (bus.slot) begin
                    ram_we_c = 1'b1;
                    upd_d    = upd_q + ADDR_ONE;
                    cnt_d    = cnt_q - 9'd1;
                    state_d  = cnt_last ? S_IDLE : S_CPRD;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the reset branch clears every register, including data and count, so nothing from an aborted operation survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            upd_q    <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
            byte_q   <= '0;
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values computed above.
            state    <= state_d;
            upd_q    <= upd_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            rd_q     <= rd_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Strobes are combinational on slot so an access lands in the very cycle it is granted.
    assign bus.ram_rd   = ram_rd_c;
    assign bus.ram_we   = ram_we_c;
    assign bus.ram_addr = (state == S_CPRD) ? src_q : upd_q;
    assign bus.ram_dai  = (state == S_CPWR) ? rd_q : byte_q;

    assign bus.busy     = (state != S_IDLE);
    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rd_vld_q;
    assign bus.upd_addr = upd_q;
    assign bus.src_addr = src_q;

endmodule

// File: tb/tb_vdc_ramctl.sv
// Self-checking bench for vdc_ramctl: a VRAM array, an access-list model of each
// operation, and a per-cycle compare of every RAM strobe against that list.
`timescale 1ns/1ps
module tb_vdc_ramctl;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vdc_ramctl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    vdc_ramctl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Video RAM: single port, read data registered one cycle after ram_rd.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.ram_rd) bus.ram_dao <= mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_dai;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state: expected access list, expected memory, expected registers.
    typedef struct {
        bit         wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;
    acc_t        exp_q[$];
    acc_t        e_pop;
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] m_upd = '0;
    logic [15:0] m_src = '0;
    logic [7:0]  exp_rd = '0;
    int          rdv_count = 0;

    // Slot generator: explicit pattern first, otherwise always-granted or random.
    int slot_mode = 0;
    bit slot_pat[$];
    initial begin
        bus.slot = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (slot_pat.size() > 0)  bus.slot = slot_pat.pop_front();
            else if (slot_mode == 0)  bus.slot = 1'b1;
            else                      bus.slot = 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle compare of RAM strobes and read-valid pulses against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ram_rd || bus.ram_we) begin
                check("strobe_in_slot", bus.slot, 1);
                check("single_strobe", bus.ram_rd & bus.ram_we, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {bus.ram_rd, bus.ram_we}, 0);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("access_kind", bus.ram_we, e_pop.wr);
                    check("access_addr", bus.ram_addr, e_pop.addr);
                    if (e_pop.wr) check("access_data", bus.ram_dai, e_pop.data);
                end
            end
            if (bus.rd_valid) begin
                rdv_count++;
                check("rd_valid_data", bus.rd_data, exp_rd);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 5000) begin
            n++;
            cyc();
        end
        check("busy_timeout", bus.busy, 0);
    endtask

    task automatic load_upd(input logic [15:0] a);
        bus.upd_ld = 1'b1; bus.upd_in = a; cyc(); bus.upd_ld = 1'b0;
        m_upd = a;
    endtask

    task automatic load_src(input logic [15:0] a);
        bus.src_ld = 1'b1; bus.src_in = a; cyc(); bus.src_ld = 1'b0;
        m_src = a;
    endtask

    task automatic do_write(input logic [7:0] d, output int n);
        exp_q.push_back('{wr: 1'b1, addr: m_upd, data: d});
        ref_mem[m_upd] = d;
        m_upd++;
        bus.wr_data = d; bus.start_wr = 1'b1; cyc(); bus.start_wr = 1'b0;
        wait_idle(n);
    endtask

    task automatic do_read(input bit gated, output int n);
        exp_q.push_back('{wr: 1'b0, addr: m_upd, data: 8'h00});
        exp_rd = ref_mem[m_upd];
        m_upd++;
        bus.start_rd = 1'b1; cyc(); bus.start_rd = 1'b0;
        if (gated) begin
            slot_pat.push_back(1'b0); slot_pat.push_back(1'b1);
            slot_pat.push_back(1'b0); slot_pat.push_back(1'b1);
        end
        wait_idle(n);
    endtask

    task automatic do_blk(input bit copy, input logic [7:0] cnt, input logic [7:0] d, output int n);
        int words;
        logic [7:0] v;
        words = (cnt == 8'd0) ? 256 : int'(cnt);
        for (int i = 0; i < words; i++) begin
            if (copy) begin
                v = ref_mem[m_src];
                exp_q.push_back('{wr: 1'b0, addr: m_src, data: 8'h00});
                exp_rd = v;
                m_src++;
            end else begin
                v = d;
            end
            exp_q.push_back('{wr: 1'b1, addr: m_upd, data: v});
            ref_mem[m_upd] = v;
            m_upd++;
        end
        bus.wr_data = d; bus.blk_cnt = cnt; bus.blk_copy = copy;
        bus.start_blk = 1'b1; cyc(); bus.start_blk = 1'b0;
        wait_idle(n);
    endtask

    task automatic end_check(input string tag);
        check({tag, "_upd_addr"}, bus.upd_addr, m_upd);
        check({tag, "_src_addr"}, bus.src_addr, m_src);
        check({tag, "_rd_data"}, bus.rd_data, exp_rd);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic mem_check(input string tag, input logic [15:0] a, input int len);
        logic [15:0] p;
        p = a;
        for (int i = 0; i < len; i++) begin
            check({tag, "_mem"}, mem[p], ref_mem[p]);
            p++;
        end
    endtask

    initial begin
        int n;
        int rdv0;
        bus.upd_ld = 0; bus.upd_in = '0; bus.src_ld = 0; bus.src_in = '0;
        bus.wr_data = '0; bus.start_wr = 0; bus.start_rd = 0; bus.start_blk = 0;
        bus.blk_copy = 0; bus.blk_cnt = '0;

        // Reset state
        repeat (2) cyc();
        check("rst_busy", bus.busy, 0);
        check("rst_ram_rd", bus.ram_rd, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_upd_addr", bus.upd_addr, 0);
        check("rst_src_addr", bus.src_addr, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_dai", bus.ram_dai, 0);
        reset = 1'b0;
        repeat (2) cyc();

        // Single write
        slot_mode = 0;
        load_upd(16'h1234);
        do_write(8'hA5, n);
        check("wr_busy_cycles", n, 1);
        check("wr_upd_literal", bus.upd_addr, 16'h1235);
        check("wr_mem_literal", mem[16'h1234], 8'hA5);
        end_check("wr");

        // Single read with slot gating 0,1,0,1
        load_upd(16'h0010);
        do_write(8'h3C, n);
        load_upd(16'h0010);
        rdv0 = rdv_count;
        do_read(1'b1, n);
        check("rd_busy_cycles", n, 3);
        check("rd_valid_now", bus.rd_valid, 1);
        check("rd_data_literal", bus.rd_data, 8'h3C);
        check("rd_upd_literal", bus.upd_addr, 16'h0011);
        end_check("rd");
        cyc();
        check("rd_valid_pulse", bus.rd_valid, 0);
        check("rd_valid_count", rdv_count - rdv0, 1);
        repeat (4) cyc();

        // Fill with count 0 (256 words) across the address wrap
        load_upd(16'hFFFE);
        do_blk(1'b0, 8'd0, 8'h20, n);
        check("fill_busy_cycles", n, 256);
        check("fill_upd_literal", bus.upd_addr, 16'h00FE);
        check("fill_first_literal", mem[16'hFFFE], 8'h20);
        check("fill_last_literal", mem[16'h00FD], 8'h20);
        end_check("fill");
        mem_check("fill", 16'hFFFE, 256);

        // Copy 3 bytes
        load_upd(16'h0100);
        do_write(8'h11, n); do_write(8'h22, n); do_write(8'h33, n);
        load_src(16'h0100);
        load_upd(16'h0800);
        rdv0 = rdv_count;
        do_blk(1'b1, 8'd3, 8'h00, n);
        check("cp_busy_cycles", n, 9);
        check("cp_src_literal", bus.src_addr, 16'h0103);
        check("cp_upd_literal", bus.upd_addr, 16'h0803);
        check("cp_rd_literal", bus.rd_data, 8'h33);
        check("cp_no_rd_valid", rdv_count - rdv0, 0);
        end_check("cp");
        mem_check("cp", 16'h0800, 3);

        // Simultaneous starts and busy lockout
        load_upd(16'h0900);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{wr: 1'b1, addr: m_upd, data: 8'h77});
            ref_mem[m_upd] = 8'h77;
            m_upd++;
        end
        bus.wr_data = 8'h77; bus.blk_cnt = 8'd2; bus.blk_copy = 1'b0;
        bus.start_blk = 1'b1; bus.start_wr = 1'b1; bus.start_rd = 1'b1;
        cyc();
        bus.start_blk = 1'b0; bus.start_rd = 1'b0;
        bus.upd_ld = 1'b1; bus.upd_in = 16'h4000; bus.src_ld = 1'b1; bus.src_in = 16'h5555;
        cyc();
        bus.start_wr = 1'b0; bus.upd_ld = 1'b0; bus.src_ld = 1'b0;
        wait_idle(n);
        check("lock_busy_cycles", n + 1, 2);
        check("lock_upd_literal", bus.upd_addr, 16'h0902);
        end_check("lock");
        mem_check("lock", 16'h0900, 2);

        // Overlapping forward copy under random slot grants
        load_upd(16'h0500);
        do_write(8'h41, n); do_write(8'h42, n); do_write(8'h43, n); do_write(8'h44, n);
        slot_mode = 2;
        load_src(16'h0500);
        load_upd(16'h0501);
        do_blk(1'b1, 8'd4, 8'h00, n);
        check("ovl_tail_literal", mem[16'h0504], 8'h41);
        end_check("ovl");
        mem_check("ovl", 16'h0500, 5);

        // Copy with source wrap, random slots
        load_src(16'hFFFF);
        load_upd(16'h2000);
        do_blk(1'b1, 8'd3, 8'h00, n);
        check("wrap_src_literal", bus.src_addr, 16'h0002);
        end_check("wrap");
        mem_check("wrap", 16'h2000, 3);

        // Reset in the middle of a copy (first CPWR cycle)
        slot_mode = 0;
        repeat (2) cyc();
        load_src(16'h0200);
        load_upd(16'h0300);
        exp_q.push_back('{wr: 1'b0, addr: 16'h0200, data: 8'h00});
        bus.blk_cnt = 8'd4; bus.blk_copy = 1'b1; bus.start_blk = 1'b1;
        cyc(); bus.start_blk = 1'b0;
        cyc(); cyc();
        check("mid_cpwr_we", bus.ram_we, 1);
        reset = 1'b1;
        exp_q.delete();
        m_upd = '0; m_src = '0; exp_rd = '0;
        cyc();
        check("mid_busy", bus.busy, 0);
        check("mid_ram_we", bus.ram_we, 0);
        check("mid_upd_addr", bus.upd_addr, 0);
        check("mid_src_addr", bus.src_addr, 0);
        check("mid_rd_data", bus.rd_data, 0);
        reset = 1'b0;
        repeat (6) cyc();
        end_check("mid");

        // Recovery after reset
        do_write(8'h5A, n);
        check("rec_busy_cycles", n, 1);
        end_check("rec");
        mem_check("rec", 16'h0000, 1);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdc_ramctl.md
Name: vdc_ramctl

Overview:
- CPU-side access engine for the VDC video RAM. It sits directly upstream of the single-port VDC RAM and drives its rd/we/addr/data lines.
- Executes single CPU reads and writes through the data register (R31) at the update address (R18/R19).
- Executes block fill and block copy operations (R30 word count, R24 bit 7 mode, R32/R33 source address).
- Issues RAM accesses only in cycles the display fetcher grants (`slot`).

Parameters:
- ADDRESS_WIDTH, 16, RAM address width; all addresses wrap modulo 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- slot  in  1  RAM access permitted this cycle
- upd_ld  in  1  pulse: load update address from upd_in
- upd_in  in  ADDRESS_WIDTH  new update address
- src_ld  in  1  pulse: load source address from src_in
- src_in  in  ADDRESS_WIDTH  new block-copy source address
- wr_data  in  DATA_WIDTH  R31 write value; also the fill byte
- start_wr  in  1  pulse: write wr_data at the update address
- start_rd  in  1  pulse: read the update address
- start_blk  in  1  pulse: start a block operation
- blk_copy  in  1  1 = copy, 0 = fill; sampled with start_blk
- blk_cnt  in  8  word count; 0 means 256; sampled with start_blk
- busy  out  1  operation in progress
- rd_data  out  DATA_WIDTH  R31 readback
- rd_valid  out  1  one-cycle pulse when rd_data updated by a read
- upd_addr  out  ADDRESS_WIDTH  current update address
- src_addr  out  ADDRESS_WIDTH  current source address
- ram_rd  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDRESS_WIDTH  RAM address
- ram_dai  out  DATA_WIDTH  RAM write data
- ram_dao  in  DATA_WIDTH  RAM read data; valid the cycle after ram_rd

Behaviour:
- Reset (async, any state, including mid-operation):
  - Aborts any operation; state IDLE.
  - busy, rd_valid, ram_rd, ram_we = 0.
  - rd_data, upd_addr, src_addr, ram_addr, ram_dai, internal count = 0.
- RAM strobes:
  - ram_rd and ram_we are asserted only in cycles with slot=1, never both in the same cycle.
  - ram_addr and ram_dai are don't-care when both strobes are 0.
  - Read latency is 1: ram_dao is captured the cycle after ram_rd, regardless of slot.
- States: IDLE, WR, RD, RDCAP, FILL, CPRD, CPCAP, CPWR.
- IDLE:
  - upd_ld / src_ld load their address registers.
  - Start pulses set busy=1 the next cycle; priority start_blk > start_wr > start_rd; lower-priority starts in the same cycle are dropped.
  - start_blk latches blk_cnt into an internal 9-bit count (0 becomes 256) and latches wr_data as the fill byte.
  - start_blk goes to FILL or CPRD per blk_copy; start_wr goes to WR (wr_data latched); start_rd goes to RD.
- While busy:
  - upd_ld, src_ld and all start pulses are ignored. The CPU side is responsible for polling busy.
- WR: on a slot, ram_we with ram_addr=upd_addr and ram_dai=latched byte; upd_addr+1; go to IDLE, busy=0 the next cycle.
- RD: on a slot, ram_rd at upd_addr, go to RDCAP.
- RDCAP: rd_data <= ram_dao, rd_valid=1 for one cycle, upd_addr+1, go to IDLE.
- FILL:
  - Each slot: write the fill byte at upd_addr, upd_addr+1, count-1.
  - When count reaches 0, go to IDLE. Exactly N writes occur for count N.
- Copy sequence:
  - CPRD: on a slot, ram_rd at src_addr, src_addr+1, go to CPCAP.
  - CPCAP: capture ram_dao into rd_data (no rd_valid), go to CPWR.
  - CPWR: on a slot, write the captured byte at upd_addr, upd_addr+1, count-1. If count is now 0 go to IDLE, else CPRD.
- Address wrap: increments past 2**ADDRESS_WIDTH-1 wrap to 0 for both addresses. Overlapping source and destination regions are copied byte-sequentially (forward).
- slot=0: the FSM holds state and all registers, except RDCAP/CPCAP, which complete regardless.
- Minimum cost with slot always 1: write 1 cycle, read 2, fill N cycles, copy 3N cycles.

Test Plan:
- Reset mid-copy: assert reset in CPWR → next clock edge busy=0, ram_we=0, upd_addr=0, no further RAM strobes.
- Single write: upd_ld upd_in=0x1234, wr_data=0xA5, start_wr, slot=1 → one ram_we at 0x1234 with 0xA5; upd_addr=0x1235; busy high exactly 1 cycle.
- Single read with slot gating: RAM[0x0010]=0x3C, slot toggling 1010 starting 0 → ram_rd at the first slot=1 cycle; next cycle rd_data=0x3C, rd_valid pulse; upd_addr=0x0011.
- Fill with count 0: upd=0xFFFE, wr_data=0x20, blk_cnt=0, fill → 256 writes at 0xFFFE, 0xFFFF, 0x0000…0x00FD; final upd_addr=0x00FE.
- Copy 3 bytes: src=0x0100 holding 11,22,33, upd=0x0800 → RAM[0x0800..0x0802]=11,22,33; src_addr=0x0103, upd_addr=0x0803, rd_data=0x33; 9 cycles with slot=1.
- Simultaneous starts plus busy lockout: start_blk and start_wr in the same cycle → only the block op runs. upd_ld during busy → ignored; upd_addr reflects the block op only.
